// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: defaults and the
// byte-address to word-index decode used by both the fetch and load paths.
package imem_pkg;

  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic        in_range;
    logic [29:0] idx;
  } addr_dec_t;

  // Offset wraps modulo 2^32, so addresses below the base land far out of range.
  function automatic addr_dec_t decode_addr(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned depth_log2);
    logic [31:0] off;
    addr_dec_t   dec;
    off          = addr - base;
    dec.idx      = off[31:2];
    dec.in_range = ((off % 32'(WORD_BYTES)) == 32'd0) &&
                   ((off[31:2] >> depth_log2) == 30'd0);
    return dec;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side request/response bundle between the program counter stage and
// the instruction-memory responder.
interface imem_responder_if;

  logic [31:0] addra;
  logic        req_a;
  logic        req_ready;
  logic [31:0] douta;
  logic        valid_b;
  logic        ready_b;
  logic        fault_b;

  modport master (
    output addra, req_a, ready_b,
    input  req_ready, douta, valid_b, fault_b
  );

  modport slave (
    input  addra, req_a, ready_b,
    output req_ready, douta, valid_b, fault_b
  );

endinterface

// File: rtl/imem_array.sv
// Word-wide register array with one synchronous write port and one synchronous
// read port; a same-edge read and write to one word returns the old word.
module imem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  // Read data holds when no read is issued, which keeps the response stable.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: returns the addressed word one cycle after an
// accepted fetch, flags faulting addresses, and offers a side program-load port.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
  input  logic                   clka,
  input  logic                   rsta,
  imem_responder_if.slave        fetch,
  input  logic                   load_en,
  input  logic [31:0]            load_addr,
  input  logic [31:0]            load_data,
  output logic                   load_err,
  output logic [31:0]            fetch_cnt
);

  addr_dec_t   fetch_dec;
  addr_dec_t   load_dec;
  logic        accept;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] rd_data;
  logic        unused_idx_bits;

  logic        valid_q,    valid_d;
  logic        fault_q,    fault_d;
  logic        nop_sel_q,  nop_sel_d;
  logic        load_err_q, load_err_d;
  logic [31:0] cnt_q,      cnt_d;

  assign fetch_dec = decode_addr(fetch.addra, BASE_ADDR, DEPTH_LOG2);
  assign load_dec  = decode_addr(load_addr, BASE_ADDR, DEPTH_LOG2);

  assign unused_idx_bits = ^{fetch_dec.idx[29:DEPTH_LOG2], load_dec.idx[29:DEPTH_LOG2]};

  assign fetch.req_ready = !valid_q | fetch.ready_b;

  // Inputs are ignored during the reset cycle, including the load strobe.
  assign accept = fetch.req_a & fetch.req_ready & !rsta;
  assign rd_en  = accept & fetch_dec.in_range;
  assign wr_en  = load_en & load_dec.in_range & !rsta;

  imem_array #(
    .ADDR_W (DEPTH_LOG2)
  ) u_array (
    .clk   (clka),
    .we    (wr_en),
    .waddr (load_dec.idx[DEPTH_LOG2-1:0]),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (fetch_dec.idx[DEPTH_LOG2-1:0]),
    .rdata (rd_data)
  );

  always_comb begin
    valid_d    = valid_q;
    fault_d    = fault_q;
    nop_sel_d  = nop_sel_q;
    cnt_d      = cnt_q;
    load_err_d = load_en & !load_dec.in_range;
    if (accept) begin
      valid_d   = 1'b1;
      fault_d   = !fetch_dec.in_range;
      nop_sel_d = !fetch_dec.in_range;
      cnt_d     = cnt_q + 32'd1;
    end else if (fetch.ready_b) begin
      valid_d   = 1'b0;
    end
  end

  // nop_sel_q substitutes NOP_WORD for the array output after reset or a fault.
  always_ff @(posedge clka) begin
    if (rsta) begin
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      nop_sel_q  <= 1'b1;
      load_err_q <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      nop_sel_q  <= nop_sel_d;
      load_err_q <= load_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fetch.valid_b = valid_q;
  assign fetch.fault_b = fault_q;
  assign fetch.douta   = nop_sel_q ? NOP_WORD : rd_data;
  assign load_err      = load_err_q;
  assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios followed by a
// randomized phase, all compared against a word-level reference model.
module tb_imem_responder;

  localparam int          DEPTH_LOG2 = 8;
  localparam int          DEPTH      = 256;
  localparam logic [31:0] BASE       = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  logic        clka = 1'b0;
  logic        rsta;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_err;
  logic [31:0] fetch_cnt;

  imem_responder_if bus ();

  imem_responder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BASE_ADDR  (BASE),
    .NOP_WORD   (NOP)
  ) dut (
    .clka      (clka),
    .rsta      (rsta),
    .fetch     (bus),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_err  (load_err),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clka = ~clka;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          ref_valid;
  bit          ref_fault;
  bit          ref_load_err;
  bit          check_data;
  logic [31:0] ref_data;
  logic [31:0] ref_cnt;

  function automatic bit addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return ((off % 32'd4) == 32'd0) && ((off / 32'd4) < DEPTH);
  endfunction

  function automatic int addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) / 32'd4;
    return int'(off);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: predict the edge from the model, then compare.
  task automatic apply_stimulus(input bit rst, input bit req, input logic [31:0] addr,
                                input bit rdy, input bit ld, input logic [31:0] la,
                                input logic [31:0] ld_data);
    bit acc;
    rsta        = rst;
    bus.req_a   = req;
    bus.addra   = addr;
    bus.ready_b = rdy;
    load_en     = ld;
    load_addr   = la;
    load_data   = ld_data;
    #1;
    check_output("req_ready", {31'b0, bus.req_ready}, {31'b0, (!ref_valid || rdy)});
    @(posedge clka);
    if (rst) begin
      ref_valid    = 1'b0;
      ref_fault    = 1'b0;
      ref_data     = NOP;
      ref_cnt      = 32'd0;
      ref_load_err = 1'b0;
      check_data   = 1'b1;
    end else begin
      acc = req && (!ref_valid || rdy);
      if (acc) begin
        ref_valid = 1'b1;
        ref_fault = !addr_ok(addr);
        ref_data  = addr_ok(addr) ? ref_mem[addr_idx(addr)] : NOP;
        ref_cnt   = ref_cnt + 32'd1;
      end else if (rdy) begin
        ref_valid = 1'b0;
      end
      check_data   = ref_valid;
      ref_load_err = ld && !addr_ok(la);
      if (ld && addr_ok(la)) begin
        ref_mem[addr_idx(la)] = ld_data;
      end
    end
    #1;
    check_output("valid_b",   {31'b0, bus.valid_b}, {31'b0, ref_valid});
    check_output("load_err",  {31'b0, load_err},    {31'b0, ref_load_err});
    check_output("fetch_cnt", fetch_cnt,            ref_cnt);
    if (check_data) begin
      check_output("fault_b", {31'b0, bus.fault_b}, {31'b0, ref_fault});
      check_output("douta",   bus.douta,            ref_data);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(9) < 8) begin
      return BASE + 32'($urandom_range(DEPTH - 1)) * 32'd4;
    end
    return $urandom;
  endfunction

  initial begin
    rsta        = 1'b1;
    bus.req_a   = 1'b0;
    bus.addra   = 32'd0;
    bus.ready_b = 1'b0;
    load_en     = 1'b0;
    load_addr   = 32'd0;
    load_data   = 32'd0;
    ref_valid    = 1'b0;
    ref_fault    = 1'b0;
    ref_load_err = 1'b0;
    ref_data     = NOP;
    ref_cnt      = 32'd0;
    check_data   = 1'b0;
    @(posedge clka);
    #1;

    $display("[TB] reset and preload");
    apply_stimulus(1'b1, 1'b1, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0);
    check_output("douta_after_reset", bus.douta, NOP);
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, BASE + 32'(i) * 32'd4, $urandom);
    end
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0, 32'h11);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h4, 32'h22);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8, 32'h33);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hC, 32'h44);

    $display("[TB] streaming fetch");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b1, 32'(i) * 32'd4, 1'b1, 1'b0, 32'd0, 32'd0);
    end
    check_output("douta_stream_last", bus.douta, 32'h44);
    idle(1);
    check_output("fetch_cnt_stream", fetch_cnt, 32'd4);

    $display("[TB] wrap and fault addresses");
    apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd0, 32'd0);
    check_output("fault_wrap", {31'b0, bus.fault_b}, 32'd1);
    apply_stimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'd0, 32'd0);
    check_output("douta_word0", bus.douta, 32'h11);
    apply_stimulus(1'b0, 1'b1, 32'h6, 1'b1, 1'b0, 32'd0, 32'd0);
    apply_stimulus(1'b0, 1'b1, 32'd1024, 1'b1, 1'b0, 32'd0, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd1024, 32'hBAD0_BAD0);
    check_output("load_err_pulse", {31'b0, load_err}, 32'd1);
    apply_stimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'd0, 32'd0);
    check_output("mem_unchanged", bus.douta, 32'h11);
    idle(1);

    $display("[TB] back-pressure");
    apply_stimulus(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    check_output("douta_held", bus.douta, 32'h22);
    apply_stimulus(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'd0, 32'd0);
    check_output("douta_released", bus.douta, 32'h33);
    idle(1);

    $display("[TB] read-before-write");
    apply_stimulus(1'b0, 1'b1, 32'h8, 1'b1, 1'b1, 32'h8, 32'hAA);
    check_output("douta_old_word", bus.douta, 32'h33);
    apply_stimulus(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'd0, 32'd0);
    check_output("douta_new_word", bus.douta, 32'hAA);
    idle(1);

    $display("[TB] reset during stall");
    apply_stimulus(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'd0, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    apply_stimulus(1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
    check_output("cnt_after_reset", fetch_cnt, 32'd0);
    apply_stimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'd0, 32'd0);
    check_output("mem_retained", bus.douta, 32'h11);
    idle(1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      apply_stimulus($urandom_range(99) == 0,
                     $urandom_range(3) != 0, rand_addr(),
                     $urandom_range(2) != 0,
                     $urandom_range(4) == 0, rand_addr(), $urandom);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder at the far end of the fetch address stream produced by the program counter. It accepts a byte address plus request, and returns the addressed 32-bit instruction word one cycle later, together with valid and fault flags. Returned words are held under downstream back-pressure. A side load port lets the testbench or boot logic write program words before or during execution.

Parameters:
- DEPTH_LOG2, 8, log2 of memory depth in 32-bit words (default 256 words).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be 4-byte aligned.
- NOP_WORD, 32'h0000_0000, instruction returned on fault and after reset.

Ports:
- clka  in  1  clock; all state updates on rising edge.
- rsta  in  1  reset, synchronous, active-high.
- addra  in  32  fetch byte address.
- req_a  in  1  fetch request; accepted when req_a & req_ready.
- req_ready  out  1  responder can accept a request this cycle.
- douta  out  32  returned instruction word.
- valid_b  out  1  douta/fault_b hold a response.
- ready_b  in  1  consumer takes the response this cycle.
- fault_b  out  1  response is for a misaligned or out-of-range address.
- load_en  in  1  write strobe for program load.
- load_addr  in  32  load byte address.
- load_data  in  32  load word.
- load_err  out  1  one-cycle pulse: last load address was misaligned or out of range.
- fetch_cnt  out  32  number of accepted requests; wraps modulo 2^32.

Behaviour:
- Reset (rsta=1 at an edge): valid_b=0, fault_b=0, douta=NOP_WORD, load_err=0, fetch_cnt=0. Memory contents are not cleared. A response in flight is discarded. req_a, ready_b and load_en are ignored in the reset cycle.
- Index calculation: off = addr - BASE_ADDR (32-bit, wraps); idx = off[31:2].
  - In range iff off[1:0]==0 and idx < 2^DEPTH_LOG2.
  - Any other address is a fault.
- req_ready = !valid_b | ready_b. This is combinational and has no dependency on req_a.
- Accept (req_a & req_ready), then at the next edge:
  - valid_b=1.
  - douta = mem[idx] if in range, else NOP_WORD.
  - fault_b = !in_range.
  - fetch_cnt += 1.
- Latency is exactly 1 cycle from accept to valid_b.
- Throughput is 1 response per cycle while ready_b=1.
- valid_b & !ready_b: douta, valid_b and fault_b are held stable and no new request is accepted.
- valid_b & ready_b & no accept: valid_b drops to 0 next edge. douta keeps its last value; this value is don't-care.
- Load: load_en with an in-range load_addr writes mem[idx] at the edge. An out-of-range load_addr causes no write and load_err=1 for one cycle.
- Simultaneous load and accepted fetch to the same idx: the fetch returns the OLD word (read-before-write).
- Address 32'hFFFF_FFFC with BASE_ADDR=0 is out of range, so it gives a fault with NOP_WORD. The next PC value 0 is word 0.
- There is no FSM beyond a 1-deep output register. The valid_b/ready_b pair follows standard valid-ready rules: valid_b never drops without ready_b, except on reset.

Decomposition:
- Shared package imem_pkg holds:
  - NOP_WORD default.
  - Word-size constant (4).
  - A function computing in_range/idx from addr, BASE_ADDR and DEPTH_LOG2, shared by the fetch and load paths.
- One sub-module, imem_array: DEPTH-word register array with one synchronous write port and one synchronous read port with read-before-write semantics. The top level holds the handshake, fault logic and counter.

Test Plan:
- Reset then load words 0..3 = 32'h11, 32'h22, 32'h33, 32'h44. Stream addra 0, 4, 8, 12 with req_a=1 and ready_b=1 -> douta 11, 22, 33, 44 on consecutive cycles, each one cycle after its request; fault_b=0; fetch_cnt=4.
- addra=32'hFFFF_FFFC then 0 -> first response fault_b=1 with douta=0; second response fault_b=0 with douta=mem[0].
- addra=32'h6 (misaligned) -> fault_b=1, douta=NOP_WORD. addra=4*256 -> fault_b=1. load_addr=4*256 -> load_err pulse, memory unchanged.
- Accept addr 4, then hold ready_b=0 for 3 cycles with req_a=1 at addr 8 -> douta stays 22, req_ready=0, fetch_cnt unchanged. Release ready_b -> 33 appears next cycle.
- In the same cycle, load mem[2]=32'hAA and fetch addr 8 -> response 33. A following fetch of addr 8 returns AA.
- Assert rsta while valid_b=1 and ready_b=0 -> next cycle valid_b=0, douta=NOP_WORD, fetch_cnt=0. A fetch of addr 0 then still returns 11, because memory is retained.
